rsa_job_ctrl: RTL
=================

Name: rsa_job_ctrl

Overview:
- Host-side initiator for the modular-exponentiation core. Computes C = P^E mod M.
- Accepts one job over a valid/ready request channel and validates the modulus.
- Precomputes the Montgomery constant Const = 2^(2*(WIDTH+2)) mod M by serial shift-subtract.
- Drives the core's enable, holds operands stable, waits for end-of-conversion and returns C over a valid/ready response channel.

Parameters:
- WIDTH, 8, operand width in bits (P, E, M, C). Core Montgomery width N = WIDTH+2.
- TIMEOUT_CYCLES, 4096, maximum cycles in RUN before abort. Used only with RSA_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rstb  in  1  asynchronous active-low reset.
- req_valid  in  1  job request present.
- req_ready  out  1  controller can accept a job.
- req_p  in  WIDTH  message/base.
- req_e  in  WIDTH  exponent.
- req_m  in  WIDTH  modulus.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  host accepts result.
- rsp_c  out  WIDTH  result.
- rsp_err  out  1  job rejected or aborted.
- core_en  out  1  core enable.
- core_p  out  WIDTH  latched P to core.
- core_e  out  WIDTH  latched E to core.
- core_m  out  WIDTH  latched M to core.
- core_const  out  WIDTH  precomputed Const to core.
- core_c  in  WIDTH  core result.
- core_eoc  in  1  core end-of-conversion.

Behaviour:
- Reset (rstb low, async): state IDLE; all registers and outputs 0 except req_ready = 1. core_en deasserts immediately. An in-flight job is discarded with no response. The core shares rstb.
- FSM states: IDLE, PRECOMP, RUN, RESP.
- IDLE:
  - req_ready = 1, core_en = 0.
  - Handshake when req_valid && req_ready. Latch p/e/m into core_p/core_e/core_m. req_ready drops the next cycle.
  - If m[0] == 0 or m < 3: rsp_c = 0, rsp_err = 1, go to RESP.
  - Else if e == 0: rsp_c = 1, rsp_err = 0, go to RESP. The core is not started.
  - Else: r = 1, iteration counter = 0, go to PRECOMP.
- PRECOMP:
  - One iteration per cycle: t = 2r (WIDTH+1 bits); r = (t >= M) ? t - M : t.
  - Runs exactly 2*(WIDTH+2) iterations. Invariant r < M, so no overflow.
  - After the last iteration, core_const = r and go to RUN.
  - core_en stays 0 throughout. This guarantees at least 2N cycles of core_en low between jobs.
- RUN:
  - core_en = 1. Operands and core_const are held constant.
  - On the first cycle with core_eoc = 1: rsp_c = core_c, rsp_err = 0, go to RESP. core_en is 0 from the next cycle.
  - core_eoc sampled in any other state is ignored.
- RESP:
  - rsp_valid = 1. rsp_c and rsp_err are held stable until rsp_ready.
  - When rsp_valid && rsp_ready: rsp_valid = 0 next cycle and go to IDLE. rsp_c/rsp_err keep their last values.
  - req_ready = 0 in RESP. No new job is accepted in the same cycle as the response handshake.
- req_valid is ignored outside IDLE. Request fields are don't-care except at the handshake.
- Latency for a normal job: 1 accept cycle + 2N PRECOMP cycles + core latency + 1 cycle to rsp_valid.
- Throughput: one job in flight.

Optional Feature:
- Macro RSA_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT_CYCLES without core_eoc: core_en = 0, rsp_c = 0, rsp_err = 1, go to RESP.
  - core_eoc arriving in the same cycle as the timeout wins; the result is returned normally.
- When not defined: no counter. RUN waits indefinitely, and rsp_err is only set for bad modulus.

Test Plan (WIDTH=8):
- P=5, E=3, M=33 -> core_const = 1 observed at RUN entry; rsp_c = 26, rsp_err = 0; core_en high only during RUN.
- P=4, E=5, M=35 -> core_const = 11; rsp_c = 9. Hold rsp_ready low 10 cycles: rsp_valid/rsp_c stable, req_ready = 0.
- M=34 (even), then M=1 -> rsp_err = 1, rsp_c = 0 within 2 cycles; core_en never asserted.
- E=0, M=33 -> rsp_c = 1, rsp_err = 0; core_en never asserted. Back-to-back jobs: core_en low ≥ 20 cycles between runs.
- Reset pulse mid-PRECOMP and mid-RUN -> core_en falls asynchronously, no rsp_valid, req_ready = 1 after release; next job (5,3,33) returns 26.
- RSA_TIMEOUT_EN with TIMEOUT_CYCLES = 16 and core_eoc tied low -> rsp_err = 1, rsp_c = 0 after 16 RUN cycles. eoc coincident with the timeout cycle -> normal result.

Source files
------------

// File: rtl/rsa_job_ctrl.sv
// rtl/rsa_job_ctrl.sv - modexp job controller: accept, Montgomery constant precompute, run core, respond
// Optional feature macro: RSA_TIMEOUT_EN (RUN-state abort after TIMEOUT_CYCLES).
module rsa_job_ctrl #(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_p,
  input  logic [WIDTH-1:0] req_e,
  input  logic [WIDTH-1:0] req_m,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_c,
  output logic             rsp_err,
  output logic             core_en,
  output logic [WIDTH-1:0] core_p,
  output logic [WIDTH-1:0] core_e,
  output logic [WIDTH-1:0] core_m,
  output logic [WIDTH-1:0] core_const,
  input  logic [WIDTH-1:0] core_c,
  input  logic             core_eoc
);
  localparam int ITERS = 2 * (WIDTH + 2);
  localparam int IW    = $clog2(ITERS + 1);

  typedef enum logic [1:0] {IDLE, PRECOMP, RUN, RESP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d, e_q, e_d, m_q, m_d;
  logic [WIDTH-1:0] r_q, r_d, const_q, const_d, c_q, c_d;
  logic             err_q, err_d;
  logic [IW-1:0]    it_q, it_d;

  // 2r never exceeds 2M-2, so the carry out of the shift plus the low bits decide t >= M,
  // and t - M always fits back into WIDTH bits.
  logic             dbl_carry;
  logic [WIDTH-1:0] dbl_low, r_next;
  assign dbl_carry = r_q[WIDTH-1];
  assign dbl_low   = {r_q[WIDTH-2:0], 1'b0};
  assign r_next    = (dbl_carry || (dbl_low >= m_q)) ? (dbl_low - m_q) : dbl_low;

`ifdef RSA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tmo_hit;
  assign tmo_hit = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    e_d     = e_q;
    m_d     = m_q;
    r_d     = r_q;
    const_d = const_q;
    c_d     = c_q;
    err_d   = err_q;
    it_d    = it_q;
`ifdef RSA_TIMEOUT_EN
    tcnt_d  = tcnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          p_d = req_p;
          e_d = req_e;
          m_d = req_m;
          if (!req_m[0] || (req_m < WIDTH'(3))) begin
            c_d     = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else if (req_e == '0) begin
            c_d     = WIDTH'(1);
            err_d   = 1'b0;
            state_d = RESP;
          end else begin
            r_d     = WIDTH'(1);
            it_d    = '0;
            state_d = PRECOMP;
          end
        end
      end
      PRECOMP: begin
        r_d  = r_next;
        it_d = it_q + IW'(1);
        if (it_q == IW'(ITERS - 1)) begin
          const_d = r_next;
          state_d = RUN;
`ifdef RSA_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end
      end
      RUN: begin
        if (core_eoc) begin
          c_d     = core_c;
          err_d   = 1'b0;
          state_d = RESP;
`ifdef RSA_TIMEOUT_EN
        end else if (tmo_hit) begin
          c_d     = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tcnt_d  = tcnt_q + TW'(1);
`endif
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      p_q     <= '0;
      e_q     <= '0;
      m_q     <= '0;
      r_q     <= '0;
      const_q <= '0;
      c_q     <= '0;
      err_q   <= 1'b0;
      it_q    <= '0;
`ifdef RSA_TIMEOUT_EN
      tcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      e_q     <= e_d;
      m_q     <= m_d;
      r_q     <= r_d;
      const_q <= const_d;
      c_q     <= c_d;
      err_q   <= err_d;
      it_q    <= it_d;
`ifdef RSA_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
`endif
    end
  end

  // Decoded straight from state so reset drops core_en without waiting for a clock.
  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign core_en    = (state_q == RUN);
  assign rsp_c      = c_q;
  assign rsp_err    = err_q;
  assign core_p     = p_q;
  assign core_e     = e_q;
  assign core_m     = m_q;
  assign core_const = const_q;

endmodule
